ascensor_input_cond: RTL and testbench
======================================

// Module: ascensor_input_cond
// PURPOSE
//  Input conditioning stage upstream of the 2-floor elevator controller FSM.
//  Synchronises and debounces the raw call buttons and floor limit switches,
//  and latches each button press into a call request until the car arrives.
//  Outputs feed the controller inputs directly:
//    call_a->PA, call_b->PB, sw_a->swa, sw_b->swb.
//  Also flags an illegal limit-switch combination.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive clocks a synced input must differ from its
//                       debounced level before that level flips; legal 2..65535
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  counter width, derived; not overridden
// PORTS
//  clk          in   1  system clock; all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  btn_a_raw    in   1  floor-A call button, asynchronous, bouncing, active-high
//  btn_b_raw    in   1  floor-B call button, asynchronous, bouncing, active-high
//  sw_a_raw     in   1  floor-A limit switch, asynchronous, bouncing, 1 = car at A
//  sw_b_raw     in   1  floor-B limit switch, asynchronous, bouncing, 1 = car at B
//  call_a       out  1  latched request for floor A (to PA)
//  call_b       out  1  latched request for floor B (to PB)
//  sw_a         out  1  debounced floor-A switch level (to swa)
//  sw_b         out  1  debounced floor-B switch level (to swb)
//  limit_fault  out  1  sticky: both debounced switches seen high together
// BEHAVIOUR
//  Reset:
//   - All sync flops, counters, debounced levels and outputs go to 0.
//   - Reset is synchronous and wins over everything.
//   - Reset mid-debounce discards the partial count; no output pulse is produced.
//  Synchroniser:
//   - Each raw input passes through 2 flops (s1, s2) before any use.
//  Debounce (identical per channel, 4 channels):
//   - Each channel has a CNT_W-bit counter and a debounced level deb.
//   - If s2 != deb: counter increments.
//   - If s2 == deb: counter clears to 0.
//   - When the increment would reach DEBOUNCE_CYCLES, deb toggles and the counter clears.
//   - Counter never wraps.
//   - Latency: if edge k is the first edge that samples a new stable raw value,
//     deb changes at edge k+DEBOUNCE_CYCLES+1.
//   - Any glitch shorter than DEBOUNCE_CYCLES clocks (after sync) never reaches deb.
//  Switch outputs:
//   - sw_a = deb(sw_a_raw), sw_b = deb(sw_b_raw), driven directly from registers.
//  Call latches (per floor X in {A,B}):
//   - set_X = rising edge of deb(btn_X), i.e. deb goes 0->1 at this edge.
//   - clr_X = deb(sw_X) next-value is 1, or limit_fault next-value is 1.
//   - call_X next-value = clr_X ? 0 : (set_X ? 1 : call_X).
//   - Clear wins over a simultaneous set.
//   - A press while the car is already at floor X never raises call_X.
//   - A held button gives one set only; a new set requires release then a new debounced press.
//   - call_A and call_B are independent; both may be 1 at once.
//  Fault:
//   - limit_fault sets at the edge where deb(sw_a) and deb(sw_b) are both 1.
//   - limit_fault stays 1 until reset.
//   - While limit_fault is 1, call_a and call_b are held at 0.
//   - sw_a and sw_b keep tracking their inputs while limit_fault is 1.
//  Outputs are registered only; no combinational path from any input to any output.
// TESTING  (DEBOUNCE_CYCLES=4 unless noted; edge 0 = first edge sampling new raw value)
//  1 Glitch reject: btn_a_raw high for 3 clocks, then low
//      -> deb stays 0, call_a stays 0 throughout.
//  2 Clean call: sw_b_raw=1 (settled), btn_a_raw rises and holds
//      -> call_a=1 after edge 5; stays 1 after btn_a_raw release.
//  3 Arrival clear: call_a=1, then sw_a_raw rises
//      -> sw_a=1 and call_a=0 both after edge 5; sw_b falls independently
//         when sw_b_raw drops.
//  4 Press at floor: sw_a=1 settled, btn_a_raw pressed 10 clocks -> call_a stays 0;
//    same edge set+clear -> clear wins.
//  5 Fault: sw_a_raw=sw_b_raw=1 for 6 clocks with call_b=1
//      -> limit_fault=1 and call_b=0 after edge 5; both held until reset.
//  6 Reset mid-count: btn_b_raw high, reset at edge 3 for 1 clock, raw kept high
//      -> call_b=0 through reset; call_b=1 after edge 4+2+4 = edge 10;
//    repeat with DEBOUNCE_CYCLES=16, expecting edge 0+17.

Source files
------------

// File: rtl/ascensor_input_cond.sv
// Input conditioning for the 2-floor elevator controller: sync + debounce of
// call buttons and limit switches, call-request latches and a sticky limit fault.

module ascensor_input_cond_deb #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic deb_nxt
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // The flip happens on the edge that would have counted to DEBOUNCE_CYCLES,
  // so the counter saturates at CNT_LAST and can never wrap.
  always_comb begin
    deb_nxt = deb;
    cnt_nxt = '0;
    if (s2 != deb) begin
      if (cnt == CNT_LAST) deb_nxt = ~deb;
      else                 cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      deb <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cnt <= cnt_nxt;
      deb <= deb_nxt;
    end
  end
endmodule

module ascensor_input_cond #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  input  logic sw_a_raw,
  input  logic sw_b_raw,
  output logic call_a,
  output logic call_b,
  output logic sw_a,
  output logic sw_b,
  output logic limit_fault
);
  localparam int NUM_CH = 4;
  localparam int CH_BTN_A = 0;
  localparam int CH_BTN_B = 1;
  localparam int CH_SW_A  = 2;
  localparam int CH_SW_B  = 3;

  logic [NUM_CH-1:0] raw_vec, deb_vec, deb_nxt;
  logic              fault_nxt, set_a, set_b, clr_a, clr_b;
  logic              call_a_nxt, call_b_nxt;

  assign raw_vec = {sw_b_raw, sw_a_raw, btn_b_raw, btn_a_raw};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ascensor_input_cond_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw     (raw_vec[i]),
      .deb     (deb_vec[i]),
      .deb_nxt (deb_nxt[i])
    );
  end

  assign sw_a = deb_vec[CH_SW_A];
  assign sw_b = deb_vec[CH_SW_B];

  // Set/clear look at next-state debounced levels so an arrival and a fresh
  // press landing on the same edge resolve in favour of the clear.
  always_comb begin
    fault_nxt  = limit_fault | (deb_nxt[CH_SW_A] & deb_nxt[CH_SW_B]);
    set_a      = ~deb_vec[CH_BTN_A] & deb_nxt[CH_BTN_A];
    set_b      = ~deb_vec[CH_BTN_B] & deb_nxt[CH_BTN_B];
    clr_a      = deb_nxt[CH_SW_A] | fault_nxt;
    clr_b      = deb_nxt[CH_SW_B] | fault_nxt;
    call_a_nxt = clr_a ? 1'b0 : (set_a | call_a);
    call_b_nxt = clr_b ? 1'b0 : (set_b | call_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      call_a      <= 1'b0;
      call_b      <= 1'b0;
      limit_fault <= 1'b0;
    end else begin
      call_a      <= call_a_nxt;
      call_b      <= call_b_nxt;
      limit_fault <= fault_nxt;
    end
  end
endmodule

// File: tb/tb_ascensor_input_cond.sv
// Self-checking bench: scripted edge-accurate scenarios plus randomized
// bouncing inputs compared against a sample-window reference model.
module tb_ascensor_input_cond;
  localparam int D   = 4;
  localparam int D16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, btn_a_raw, btn_b_raw, sw_a_raw, sw_b_raw;
  logic call_a, call_b, sw_a, sw_b, limit_fault;

  logic r16, ba16, bb16, sa16, sb16;
  logic ca16, cb16, swa16, swb16, flt16;

  int n_cmp  = 0;
  int n_fail = 0;

  ascensor_input_cond #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btn_a_raw(btn_a_raw), .btn_b_raw(btn_b_raw),
    .sw_a_raw(sw_a_raw), .sw_b_raw(sw_b_raw), .call_a(call_a), .call_b(call_b),
    .sw_a(sw_a), .sw_b(sw_b), .limit_fault(limit_fault)
  );

  ascensor_input_cond #(.DEBOUNCE_CYCLES(D16)) dut16 (
    .clk(clk), .reset(r16), .btn_a_raw(ba16), .btn_b_raw(bb16),
    .sw_a_raw(sa16), .sw_b_raw(sb16), .call_a(ca16), .call_b(cb16),
    .sw_a(swa16), .sw_b(swb16), .limit_fault(flt16)
  );

  // Reference model: a level flips once the last D synchronised samples all
  // disagree with it; the synchroniser is a plain two-sample delay.
  logic [3:0] m_d1, m_d2, m_deb;
  logic       m_ca, m_cb, m_flt;
  logic [3:0] hq[$];

  task automatic model_step();
    logic [3:0] s2v, nd;
    logic       nflt, all_diff;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_deb = '0;
      m_ca = 1'b0; m_cb = 1'b0; m_flt = 1'b0;
      hq.delete();
    end else begin
      s2v  = m_d2;
      m_d2 = m_d1;
      m_d1 = {sw_b_raw, sw_a_raw, btn_b_raw, btn_a_raw};
      hq.push_back(s2v);
      if (hq.size() > D) void'(hq.pop_front());
      nd = m_deb;
      for (int ch = 0; ch < 4; ch++) begin
        all_diff = (hq.size() == D);
        foreach (hq[i]) if (hq[i][ch] == m_deb[ch]) all_diff = 1'b0;
        if (all_diff) nd[ch] = ~m_deb[ch];
      end
      nflt = m_flt | (nd[2] & nd[3]);
      if (nd[2] | nflt)              m_ca = 1'b0;
      else if (!m_deb[0] && nd[0])   m_ca = 1'b1;
      if (nd[3] | nflt)              m_cb = 1'b0;
      else if (!m_deb[1] && nd[1])   m_cb = 1'b1;
      m_deb = nd;
      m_flt = nflt;
    end
  endtask

  always @(posedge clk) model_step();

  // Returns 1 ns after a rising edge, so outputs are settled and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; r16 = 1'b1;
    btn_a_raw = 0; btn_b_raw = 0; sw_a_raw = 0; sw_b_raw = 0;
    ba16 = 0; bb16 = 0; sa16 = 0; sb16 = 0;
    repeat (3) tick();
    n_cmp++;
    if ({call_a, call_b, sw_a, sw_b, limit_fault} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {call_a, call_b, sw_a, sw_b, limit_fault});
    end
    n_cmp++;
    if ({ca16, cb16, swa16, swb16, flt16} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs16: got %b expected 00000", {ca16, cb16, swa16, swb16, flt16});
    end
    reset = 1'b0; r16 = 1'b0;
  endtask

  task automatic test_glitch();
    btn_a_raw = 1'b1;
    repeat (3) tick();
    btn_a_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if (call_a !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_call_a k=%0d: got %b expected 0", k, call_a);
      end
    end
  endtask

  task automatic test_clean_call();
    sw_b_raw = 1'b1;
    repeat (8) tick();
    btn_a_raw = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 4 || k == 5) begin
        n_cmp++;
        if (call_a !== (k == 5)) begin
          n_fail++;
          $display("FAIL clean_call edge=%0d: got %b expected %b", k, call_a, k == 5);
        end
      end
    end
    btn_a_raw = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (call_a !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_call_hold: got %b expected 1", call_a);
    end
  endtask

  task automatic test_arrival();
    sw_a_raw = 1'b1;
    sw_b_raw = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k >= 4) begin
        n_cmp++;
        if ({call_a, sw_a, sw_b} !== ((k == 5) ? 3'b010 : 3'b101)) begin
          n_fail++;
          $display("FAIL arrival edge=%0d: got %b expected %b", k, {call_a, sw_a, sw_b},
                   (k == 5) ? 3'b010 : 3'b101);
        end
      end
    end
  endtask

  task automatic test_press_at_floor();
    btn_a_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (call_a !== 1'b0) begin
        n_fail++;
        $display("FAIL press_at_floor k=%0d: got %b expected 0", k, call_a);
      end
    end
    btn_a_raw = 1'b0; sw_a_raw = 1'b0;
    repeat (8) tick();
    btn_a_raw = 1'b1; sw_a_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if (call_a !== 1'b0 || (k == 5 && sw_a !== 1'b1)) begin
        n_fail++;
        $display("FAIL same_edge_set_clr k=%0d: got call_a=%b sw_a=%b expected call_a=0", k, call_a, sw_a);
      end
    end
    btn_a_raw = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    logic [1:0] sw;
    hold = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 8);
        btn_a_raw = 1'($urandom_range(0, 1));
        btn_b_raw = 1'($urandom_range(0, 1));
        sw = 2'($urandom_range(0, 2));
        {sw_b_raw, sw_a_raw} = sw;
      end
      hold--;
      tick();
      n_cmp++;
      if ({call_a, call_b, sw_a, sw_b, limit_fault} !== {m_ca, m_cb, m_deb[2], m_deb[3], m_flt}) begin
        n_fail++;
        $display("FAIL random k=%0d: got %b expected %b", k, {call_a, call_b, sw_a, sw_b, limit_fault},
                 {m_ca, m_cb, m_deb[2], m_deb[3], m_flt});
      end
    end
  endtask

  task automatic test_fault();
    reset = 1'b1;
    btn_a_raw = 0; btn_b_raw = 0; sw_a_raw = 1; sw_b_raw = 0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    btn_b_raw = 1'b1;
    repeat (8) tick();
    btn_b_raw = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if ({call_b, sw_a, limit_fault} !== 3'b110) begin
      n_fail++;
      $display("FAIL fault_setup: got %b expected 110", {call_b, sw_a, limit_fault});
    end
    sw_b_raw = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k >= 4) begin
        n_cmp++;
        if ({limit_fault, call_b} !== ((k == 5) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL fault edge=%0d: got %b expected %b", k, {limit_fault, call_b},
                   (k == 5) ? 2'b10 : 2'b01);
        end
      end
    end
    sw_a_raw = 1'b0; sw_b_raw = 1'b0; btn_a_raw = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if ({limit_fault, call_a, call_b, sw_a, sw_b} !== 5'b10000) begin
      n_fail++;
      $display("FAIL fault_sticky: got %b expected 10000", {limit_fault, call_a, call_b, sw_a, sw_b});
    end
    btn_a_raw = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (limit_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_reset: got %b expected 0", limit_fault);
    end
  endtask

  task automatic test_reset_mid();
    repeat (8) tick();
    btn_b_raw = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      tick();
      if (k == 3) reset = 1'b1;
      if (k == 4) reset = 1'b0;
      if (k >= 3) begin
        n_cmp++;
        if (call_b !== (k >= 10)) begin
          n_fail++;
          $display("FAIL reset_mid edge=%0d: got %b expected %b", k, call_b, k >= 10);
        end
      end
    end
    btn_b_raw = 1'b0;
  endtask

  task automatic test_long_debounce();
    bb16 = 1'b1;
    repeat (15) tick();
    bb16 = 1'b0;
    repeat (25) tick();
    n_cmp++;
    if (cb16 !== 1'b0) begin
      n_fail++;
      $display("FAIL long_glitch: got %b expected 0", cb16);
    end
    bb16 = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      tick();
      if (k >= 16) begin
        n_cmp++;
        if (cb16 !== (k == 17)) begin
          n_fail++;
          $display("FAIL long_call edge=%0d: got %b expected %b", k, cb16, k == 17);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_glitch();
    test_clean_call();
    test_arrival();
    test_press_at_floor();
    test_random();
    test_fault();
    test_reset_mid();
    test_long_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
